l1cache_nw_sa_wb: RTL and testbench

// Parametrised N-way set-associative, write-back, write-allocate L1 data cache, one 32-bit word per line.

---
 rtl/l1cache_nw_sa_wb.sv | 275 +++++++++++++++++++++++++++
 tb/tb_l1cache_nw_sa_wb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1cache_nw_sa_wb.sv
// N-way set-associative write-back/write-allocate L1 data cache, one word per line.
// Clock (second-chance) replacement per set; blocking next-level request/ack port.
`timescale 1ns/1ps
module l1cache_nw_sa_wb #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int NUM_SETS = 128,
  parameter int NUM_WAYS = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              awvalid,
  input  logic              wvalid,
  input  logic              arvalid,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              r_hit,
  output logic [1:0]        r_resp,
  output logic              w_hit,
  output logic [1:0]        w_resp,
  output logic              w_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = ADDR_W - SET_W - 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_EVICT   = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_INSTALL = 3'd4;

  logic [2:0]        state;
  logic              req_wr;
  logic [SET_W-1:0]  req_set;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] req_wdata;
  logic [WAY_W-1:0]  victim_q;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] refb_q  [NUM_SETS];
  logic [WAY_W-1:0]    hand_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_ram  [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0]   data_ram [NUM_SETS][NUM_WAYS];

  // Byte-offset bits carry no information for a word-per-line cache
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr[1:0];

  assign ready = (state == S_IDLE);

  logic             hit;
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_set][w] && (tag_ram[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  logic [WAY_W-1:0]    cur_hand;
  logic [WAY_W-1:0]    scan_way;
  logic [WAY_W-1:0]    victim;
  logic                found_inv;
  logic                found_nr;
  logic [NUM_WAYS-1:0] skip_mask;
  logic [NUM_WAYS-1:0] set_valid;
  logic [NUM_WAYS-1:0] set_ref;

  // Second-chance scan from the hand; if every ref is set the mask covers
  // all ways and the victim stays at the hand, which is the wrap-around case.
  always_comb begin
    cur_hand  = hand_q[req_set];
    set_valid = valid_q[req_set];
    set_ref   = refb_q[req_set];
    found_inv = 1'b0;
    found_nr  = 1'b0;
    skip_mask = '0;
    victim    = cur_hand;
    scan_way  = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      scan_way = cur_hand + WAY_W'(i);
      if (!found_inv && !set_valid[scan_way]) begin
        found_inv = 1'b1;
        victim    = scan_way;
      end
    end
    if (!found_inv) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        scan_way = cur_hand + WAY_W'(i);
        if (!found_nr) begin
          if (!set_ref[scan_way]) begin
            found_nr = 1'b1;
            victim   = scan_way;
          end else begin
            skip_mask[scan_way] = 1'b1;
          end
        end
      end
    end
  end

  logic              ram_we;
  logic [WAY_W-1:0]  ram_way;
  logic [DATA_W-1:0] ram_data;

  always_comb begin
    ram_we   = 1'b0;
    ram_way  = victim_q;
    ram_data = req_wdata;
    case (state)
      S_LOOKUP: begin
        ram_way = hit_way;
        ram_we  = hit && req_wr;
      end
      S_FILL: begin
        ram_we   = mem_req && mem_ack && !mem_err;
        ram_data = mem_rdata;
      end
      S_INSTALL: ram_we = 1'b1;
      default: ram_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      tag_ram[req_set][ram_way]  <= req_tag;
      data_ram[req_set][ram_way] <= ram_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      req_wr    <= 1'b0;
      req_set   <= '0;
      req_tag   <= '0;
      req_wdata <= '0;
      victim_q  <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      r_hit     <= 1'b0;
      r_resp    <= 2'b00;
      w_done    <= 1'b0;
      w_hit     <= 1'b0;
      w_resp    <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        refb_q[s]  <= '0;
        hand_q[s]  <= '0;
      end
    end else begin
      rvalid <= 1'b0;
      rdata  <= '0;
      r_hit  <= 1'b0;
      r_resp <= 2'b00;
      w_done <= 1'b0;
      w_hit  <= 1'b0;
      w_resp <= 2'b00;
      case (state)
        S_IDLE: begin
          if (awvalid && wvalid) begin
            req_wr    <= 1'b1;
            req_set   <= data_addr[SET_W+1:2];
            req_tag   <= data_addr[ADDR_W-1:SET_W+2];
            req_wdata <= wdata;
            state     <= S_LOOKUP;
          end else if (arvalid) begin
            req_wr  <= 1'b0;
            req_set <= data_addr[SET_W+1:2];
            req_tag <= data_addr[ADDR_W-1:SET_W+2];
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            refb_q[req_set][hit_way] <= 1'b1;
            if (req_wr) begin
              dirty_q[req_set][hit_way] <= 1'b1;
              w_done <= 1'b1;
              w_hit  <= 1'b1;
            end else begin
              rvalid <= 1'b1;
              r_hit  <= 1'b1;
              rdata  <= data_ram[req_set][hit_way];
            end
            state <= S_IDLE;
          end else begin
            victim_q        <= victim;
            hand_q[req_set] <= victim + WAY_W'(1);
            if (!found_inv) refb_q[req_set] <= set_ref & ~skip_mask;
            if (set_valid[victim] && dirty_q[req_set][victim]) state <= S_EVICT;
            else if (req_wr)                                  state <= S_INSTALL;
            else                                              state <= S_FILL;
          end
        end
        S_EVICT: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_ram[req_set][victim_q], req_set, 2'b00};
            mem_wdata <= data_ram[req_set][victim_q];
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mem_err) begin
              if (req_wr) begin
                w_done <= 1'b1;
                w_resp <= 2'b10;
              end else begin
                rvalid <= 1'b1;
                r_resp <= 2'b10;
              end
              state <= S_IDLE;
            end else begin
              dirty_q[req_set][victim_q] <= 1'b0;
              state <= req_wr ? S_INSTALL : S_FILL;
            end
          end
        end
        S_FILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_set, 2'b00};
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            rvalid  <= 1'b1;
            dirty_q[req_set][victim_q] <= 1'b0;
            if (mem_err) begin
              r_resp <= 2'b10;
              valid_q[req_set][victim_q] <= 1'b0;
            end else begin
              rdata <= mem_rdata;
              valid_q[req_set][victim_q] <= 1'b1;
              refb_q[req_set][victim_q]  <= 1'b1;
            end
            state <= S_IDLE;
          end
        end
        S_INSTALL: begin
          valid_q[req_set][victim_q] <= 1'b1;
          dirty_q[req_set][victim_q] <= 1'b1;
          refb_q[req_set][victim_q]  <= 1'b1;
          w_done <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1cache_nw_sa_wb.sv
// Randomised bench for l1cache_nw_sa_wb against an array-based model of the
// cache contents and clock replacement, with a scripted next-level memory.
`timescale 1ns/1ps
module tb_l1cache_nw_sa_wb;

  localparam int NS = 128;
  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [19:0] data_addr;
  logic [31:0] wdata;
  logic        awvalid, wvalid, arvalid;
  logic        ready, rvalid, r_hit, w_hit, w_done;
  logic [31:0] rdata;
  logic [1:0]  r_resp, w_resp;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  l1cache_nw_sa_wb dut (
    .clk(clk), .rstn(rstn), .data_addr(data_addr), .wdata(wdata),
    .awvalid(awvalid), .wvalid(wvalid), .arvalid(arvalid), .ready(ready),
    .rvalid(rvalid), .rdata(rdata), .r_hit(r_hit), .r_resp(r_resp),
    .w_hit(w_hit), .w_resp(w_resp), .w_done(w_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model of the cache contents
  bit          mv   [NS][NW];
  bit          md   [NS][NW];
  bit          mr   [NS][NW];
  int          mt   [NS][NW];
  logic [31:0] mdat [NS][NW];
  int          mh   [NS];

  typedef struct {
    bit          we;
    logic [19:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } mop_t;
  mop_t expq[$];

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      mh[s] = 0;
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 0; md[s][w] = 0; mr[s][w] = 0;
      end
    end
  endfunction

  function automatic int pick_victim(input int s);
    for (int k = 0; k < NW; k++)
      if (!mv[s][(mh[s] + k) % NW]) return (mh[s] + k) % NW;
    for (int k = 0; k < NW; k++) begin
      int w = (mh[s] + k) % NW;
      if (!mr[s][w]) return w;
      mr[s][w] = 0;
    end
    return mh[s];
  endfunction

  task automatic do_op(input bit wr, input logic [19:0] addr, input logic [31:0] wd,
                       input logic [31:0] fdata, input bit ev_err, input bit fl_err,
                       input bit also_rd);
    int s, tg, hw, v, cyc;
    bit done, ack_pend, evicting;
    mop_t op;
    logic [31:0] e_data;
    logic [1:0]  e_resp;
    bit          e_hit;
    s  = int'(addr[8:2]);
    tg = int'(addr[19:9]);
    hw = -1;
    for (int w = 0; w < NW; w++) if (mv[s][w] && mt[s][w] == tg) hw = w;
    expq.delete();
    e_data = 0; e_resp = 2'b00; e_hit = 0;
    if (hw >= 0) begin
      e_hit = 1;
      mr[s][hw] = 1;
      if (wr) begin mdat[s][hw] = wd; md[s][hw] = 1; end
      else e_data = mdat[s][hw];
    end else begin
      v = pick_victim(s);
      mh[s] = (v + 1) % NW;
      evicting = mv[s][v] && md[s][v];
      if (evicting) begin
        op.we = 1; op.addr = 20'((mt[s][v] << 9) | (s << 2)); op.wdata = mdat[s][v];
        op.err = ev_err; op.rdata = 0;
        expq.push_back(op);
      end
      if (evicting && ev_err) begin
        e_resp = 2'b10;
      end else begin
        md[s][v] = 0;
        if (!wr) begin
          op.we = 0; op.addr = {addr[19:2], 2'b00}; op.wdata = 0;
          op.err = fl_err; op.rdata = fdata;
          expq.push_back(op);
          if (fl_err) begin
            e_resp = 2'b10; mv[s][v] = 0;
          end else begin
            mv[s][v] = 1; mr[s][v] = 1; mt[s][v] = tg; mdat[s][v] = fdata; e_data = fdata;
          end
        end else begin
          mv[s][v] = 1; md[s][v] = 1; mr[s][v] = 1; mt[s][v] = tg; mdat[s][v] = wd;
        end
      end
    end

    chk("ready_before_req", ready, 1);
    data_addr = addr; wdata = wd;
    awvalid = wr; wvalid = wr; arvalid = !wr || also_rd;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    if (!also_rd) arvalid = 0;

    cyc = 0; done = 0; ack_pend = 0;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (ack_pend) begin
        mem_ack = 0; mem_err = 0; mem_rdata = 0; ack_pend = 0;
        chk("mem_req_drop", mem_req, 0);
      end
      if (cyc == 1) begin
        chk("pulse_clear", {28'd0, rvalid, w_done, r_hit, w_hit}, 0);
        chk("rdata_idle", rdata, 0);
      end
      if (mem_req) begin
        if (expq.size() == 0) begin
          chk("mem_req_unexpected", mem_req, 0);
          mem_ack = 1; mem_err = 0; mem_rdata = 0;
        end else begin
          op = expq.pop_front();
          chk("mem_we", mem_we, op.we);
          chk("mem_addr", mem_addr, op.addr);
          if (op.we) chk("mem_wdata", mem_wdata, op.wdata);
          mem_ack = 1; mem_err = op.err; mem_rdata = op.rdata;
        end
        ack_pend = 1;
      end
      if (rvalid || w_done) done = 1;
    end
    if (!done) chk("resp_timeout", rvalid | w_done, 1);
    chk("mem_ops_left", expq.size(), 0);
    if (e_hit) chk("hit_latency", cyc, 2);
    chk("rvalid", rvalid, !wr);
    chk("w_done", w_done, wr);
    if (wr) begin
      chk("w_hit", w_hit, e_hit);
      chk("w_resp", w_resp, e_resp);
    end else begin
      chk("r_hit", r_hit, e_hit);
      chk("r_resp", r_resp, e_resp);
      chk("rdata", rdata, e_data);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [19:0] a;
    rstn = 0; data_addr = 0; wdata = 0; awvalid = 0; wvalid = 0; arvalid = 0;
    mem_ack = 0; mem_err = 0; mem_rdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_w_done", w_done, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    rstn = 1;
    @(negedge clk);

    // Cold read then hit
    do_op(0, 20'h00010, 0, 32'hDEADBEEF, 0, 0, 0);
    do_op(0, 20'h00010, 0, 32'h0, 0, 0, 0);
    // Write-allocate without memory traffic, then read hit
    do_op(1, 20'h00020, 32'h12345678, 0, 0, 0, 0);
    do_op(0, 20'h00020, 0, 0, 0, 0, 0);
    // Fill set 0 with dirty lines, then force a writeback of way 0
    for (int t = 0; t < 8; t++) do_op(1, 20'(t << 9), 32'hA000_0000 + t, 0, 0, 0, 0);
    do_op(1, 20'h01000, 32'hBEEF0008, 0, 0, 0, 0);
    do_op(0, 20'h01000, 0, 0, 0, 0, 0);
    // Fill error leaves the line absent
    do_op(0, 20'h00040, 0, 32'h5555AAAA, 0, 1, 0);
    do_op(0, 20'h00040, 0, 32'h13579BDF, 0, 0, 0);
    // Writeback error on a dirty victim
    do_op(1, 20'h01200, 32'hCAFE0009, 0, 1, 0, 0);
    do_op(0, 20'h01200, 0, 32'h77777777, 0, 0, 0);
    // Simultaneous write and read: write first, held read next
    do_op(1, 20'h00080, 32'h0BADF00D, 0, 0, 0, 1);
    do_op(0, 20'h00080, 0, 0, 0, 0, 0);

    // awvalid without wvalid is not accepted
    data_addr = 20'h3F004; wdata = 32'h1; awvalid = 1; wvalid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("aw_only_ready", ready, 1);
      chk("aw_only_mem_req", mem_req, 0);
      chk("aw_only_w_done", w_done, 0);
    end
    awvalid = 0;

    // Randomised traffic over a few sets to force replacement
    for (int n = 0; n < 400; n++) begin
      a = 20'(($urandom_range(0, 15) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      do_op($urandom_range(0, 1), a, $urandom, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 0);
    end

    // Reset while a writeback waits for its ack
    for (int t = 0; t < 8; t++) do_op(1, 20'((t << 9) | (9 << 2)), 32'hC000_0000 + t, 0, 0, 0, 0);
    data_addr = 20'((20 << 9) | (9 << 2)); wdata = 32'h99; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    cyc = 0;
    while (!mem_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("evict_req_seen", mem_req, 1);
    rstn = 0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_w_done", w_done, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    do_op(0, 20'((3 << 9) | (9 << 2)), 0, 32'h2468ACE0, 0, 0, 0);
    do_op(0, 20'h00010, 0, 32'h11223344, 0, 0, 0);
    do_op(0, 20'h00010, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
